// File: rtl/wb_regfile_pkg.sv
// Shared core constants for the integer register file and the writeback-select encoding
// used by the control unit, the MEM/WB register and the writeback stage.
package wb_regfile_pkg;

    localparam int XLEN      = 64;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/regfile_read_port.sv
// One decode-stage read port: x0 check, same-cycle writeback bypass, then array lookup.
module regfile_read_port #(
    parameter int XLEN = wb_regfile_pkg::XLEN,
    parameter int NREG = wb_regfile_pkg::NREG
) (
    input  logic [wb_regfile_pkg::REG_IDX_W-1:0] rs,
    input  logic                                 wb_reg_write,
    input  logic [wb_regfile_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]                      wb_write_data,
    input  logic [XLEN-1:0]                      regs [NREG],
    output logic [XLEN-1:0]                      rs_data
);
    import wb_regfile_pkg::*;

    // NOTE: every path of this always_comb assigns rs_data, so no latch is inferred.
    always_comb begin
        if (rs == REG_ZERO) begin
            rs_data = '0;
        end else if (wb_reg_write && (wb_rd == rs)) begin
            rs_data = wb_write_data;
        end else begin
            rs_data = regs[rs];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects load data or ALU result, commits it to the 32 x XLEN register
// file, serves both decode read ports with bypass, and counts retired writes.
module wb_regfile #(
    parameter int XLEN  = wb_regfile_pkg::XLEN,
    parameter int NREG  = wb_regfile_pkg::NREG,
    parameter int CNT_W = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [XLEN-1:0]                      wb_read_data,
    input  logic [XLEN-1:0]                      wb_result,
    input  logic                                 wb_reg_write,
    input  logic                                 wb_mem_to_reg,
    input  logic [wb_regfile_pkg::REG_IDX_W-1:0] wb_rd,
    input  logic [wb_regfile_pkg::REG_IDX_W-1:0] rs1,
    input  logic [wb_regfile_pkg::REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]                      rs1_data,
    output logic [XLEN-1:0]                      rs2_data,
    output logic [XLEN-1:0]                      wb_write_data,
    output logic [CNT_W-1:0]                     retire_count
);
    import wb_regfile_pkg::*;

    logic [XLEN-1:0] regs [NREG];
    logic            commit;

    always_comb begin
        wb_write_data = wb_result;
        if (wb_sel_e'(wb_mem_to_reg) == WB_SEL_MEM) begin
            wb_write_data = wb_read_data;
        end
    end

    // x0 writes are dropped entirely: not stored and not counted.
    assign commit = wb_reg_write && (wb_rd != REG_ZERO);

    // NOTE: the array is built from flops rather than a RAM macro because every entry
    // must clear asynchronously on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            // NOTE: state is updated with non-blocking assignments so every reader in this
            // cycle sees the pre-edge value; blocking here would race with other processes.
            regs[wb_rd] <= wb_write_data;
        end
    end

    // Wraps modulo 2^CNT_W silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count <= '0;
        end else if (commit) begin
            retire_count <= retire_count + CNT_W'(1);
        end
    end

    regfile_read_port #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rd_port1 (
        .rs            (rs1),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .regs          (regs),
        .rs_data       (rs1_data)
    );

    regfile_read_port #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rd_port2 (
        .rs            (rs2),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .regs          (regs),
        .rs_data       (rs2_data)
    );

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register in the 64-bit RISC-V pipelined core.
- Selects the writeback value (load data vs. ALU result) and commits it to a 32 x XLEN integer register file.
- Serves the two decode-stage read ports, with a same-cycle write-to-read bypass and x0 hardwired to zero.
- Keeps a retired-write counter for debug/performance.

Parameters:
XLEN, 64, datapath and register width.
NREG, 32, number of architectural registers; index width is log2(NREG) = 5.
CNT_W, 32, width of the retired-write counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
wb_read_data  input  XLEN  load data from MEM/WB.
wb_result  input  XLEN  ALU result from MEM/WB.
wb_reg_write  input  1  register write enable from MEM/WB.
wb_mem_to_reg  input  1  1 selects wb_read_data, 0 selects wb_result.
wb_rd  input  5  destination register index.
rs1  input  5  decode read port 1 index.
rs2  input  5  decode read port 2 index.
rs1_data  output  XLEN  read port 1 data, combinational.
rs2_data  output  XLEN  read port 2 data, combinational.
wb_write_data  output  XLEN  selected writeback value, combinational; drives the EX forwarding mux.
retire_count  output  CNT_W  number of committed register writes.

Behaviour:
- Clock and reset: one clock. reset is asynchronous and active-high; it is named clk/reset as elsewhere in the core.
- Reset: all NREG registers clear to 0 and retire_count clears to 0. Clearing is immediate on reset assertion, without waiting for a clock edge.
- Combinational outputs during reset: they follow the cleared state.
  - rs1_data/rs2_data = 0 unless bypass applies.
  - The bypass stays active, because the write inputs are combinational.
- Writeback select: wb_write_data = wb_mem_to_reg ? wb_read_data : wb_result. This holds regardless of wb_reg_write.
- Commit: on rising clk with reset low, if wb_reg_write = 1 and wb_rd != 0:
  - regs[wb_rd] <= wb_write_data.
  - retire_count <= retire_count + 1.
- Writes to x0 (wb_rd = 0) are dropped and are not counted.
- Write latency: 1 cycle into the array. Through the bypass the new value is visible on the read ports in the same cycle.
- Read port n (n = 1, 2), in priority order:
  1. rsn = 0 -> 0.
  2. wb_reg_write = 1 and wb_rd = rsn -> wb_write_data (bypass).
  3. Otherwise -> regs[rsn].
- rs1 = rs2: both ports return the identical value, including when bypassed.
- retire_count wraps modulo 2^CNT_W: all ones + 1 = 0, with no flag.
- Reset asserted in the middle of a cycle with a pending write: reset wins; no write occurs and the count stays 0.
- Reset deasserted: the first rising edge with reset low performs a normal commit.
- No stall or flush inputs. The MEM/WB register is responsible for injecting bubbles by setting wb_reg_write = 0.

Decomposition:
- Shared core package:
  - XLEN, NREG and REG_IDX_W = 5.
  - Constant REG_ZERO = 5'd0.
  - The writeback-select encoding: WB_SEL_ALU = 0, WB_SEL_MEM = 1. This encoding is shared with the control unit and the MEM/WB register.
- One natural sub-module: regfile_read_port, which performs the x0 check, the bypass compare and the array lookup.
  - Instantiated twice, once for rs1 and once for rs2.
- The select mux, the array and the counter stay at top level.

Test Plan:
- Reset: assert reset asynchronously between edges -> retire_count = 0 immediately. With all write inputs idle, rs1 = 5, rs2 = 31 read 0.
- Basic commit with MEM select: wb_reg_write = 1, wb_rd = 3, wb_mem_to_reg = 1, wb_read_data = 64'hDEAD_BEEF_0000_0001.
  - After the edge: rs1 = 3 -> 64'hDEAD_BEEF_0000_0001 and retire_count = 1.
- ALU select plus bypass: in the same cycle, write wb_rd = 7, wb_result = 64'h1234 with rs1 = rs2 = 7.
  - Before the edge: both ports = 64'h1234.
  - After the edge with wb_reg_write = 0: still 64'h1234.
- x0 protection: wb_reg_write = 1, wb_rd = 0, wb_result = 64'hFFFF.
  - rs1 = 0 -> 0 both before and after the edge.
  - wb_write_data = 64'hFFFF.
  - retire_count unchanged.
- Disabled write and wrap: wb_reg_write = 0, wb_rd = 4 -> regs[4] unchanged and no bypass. Then force retire_count to all ones and commit once -> retire_count = 0.
- Reset mid-operation: pending write wb_rd = 9, wb_result = 64'hA5 with reset asserted across the edge -> rs1 = 9 reads 0 after reset is released and the bypass is inactive; retire_count = 0.
